// File: rtl/fft_butterfly_sequencer.sv
// Address and control sequencer for an in-place radix-2 DIF FFT butterfly.
// Issues one operand/twiddle read per cycle, stage by stage, draining the butterfly pipe between stages.
module fft_butterfly_sequencer #(
    parameter int FFT_N  = 10,
    parameter int RD_LAT = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [$clog2(FFT_N):0]  stage,
    output logic                    rd_en,
    output logic [FFT_N-1:0]        rd_addr_a,
    output logic [FFT_N-1:0]        rd_addr_b,
    output logic [FFT_N-2:0]        tw_addr,
    output logic                    bf_iact,
    output logic [1:0]              bf_ictrl,
    output logic [FFT_N-2:0]        bf_addr,
    input  logic                    bf_oact
);

    localparam int SW = $clog2(FFT_N) + 1;
    localparam int KW = FFT_N - 1;
    localparam int PW = 1 + 2 + KW;
    localparam logic [SW-1:0] LAST_STAGE = SW'(FFT_N - 1);
    localparam logic [KW-1:0] K_LAST     = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [SW-1:0]              stage_q, stage_d;
    logic [KW-1:0]              k_q, k_d;
    logic [FFT_N-1:0]           outst_q, outst_d;
    logic [RD_LAT-1:0][PW-1:0]  pipe_q, pipe_d;

    logic [FFT_N-1:0] span, low_mask, k_ext, addr_a;
    logic [KW-1:0]    tw_k;
    logic [1:0]       cur_ictrl;

    // Sequencing FSM; DRAIN exit is judged on the registered outstanding count.
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        k_d     = k_q;
        done    = 1'b0;
        rd_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ISSUE;
                    stage_d = '0;
                    k_d     = '0;
                end
            end
            ISSUE: begin
                rd_en = 1'b1;
                k_d   = k_q + KW'(1);
                if (k_q == K_LAST) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (outst_q == '0) begin
                    if (stage_q == LAST_STAGE) begin
                        state_d = IDLE;
                        done    = 1'b1;
                        stage_d = '0;
                    end else begin
                        state_d = ISSUE;
                        stage_d = stage_q + SW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy = (state_q != IDLE) && !done;
    end

    always_comb begin
        outst_d = outst_q;
        case ({rd_en, bf_oact})
            2'b10:   outst_d = outst_q + FFT_N'(1);
            2'b01:   outst_d = outst_q - FFT_N'(1);
            default: outst_d = outst_q;
        endcase
    end

    // Operand A is k with a zero inserted at the span bit; B sets that bit.
    always_comb begin
        span      = FFT_N'(1) << (LAST_STAGE - stage_q);
        low_mask  = span - FFT_N'(1);
        k_ext     = {1'b0, k_q};
        addr_a    = ((k_ext & ~low_mask) << 1) | (k_ext & low_mask);
        tw_k      = k_q & low_mask[KW-1:0];
        rd_addr_a = rd_en ? addr_a : '0;
        rd_addr_b = rd_en ? (addr_a | span) : '0;
        tw_addr   = rd_en ? (tw_k << stage_q) : '0;
        stage     = stage_q;
        cur_ictrl = {rd_en && (k_q == K_LAST) && (stage_q == LAST_STAGE),
                     rd_en && (k_q == '0)};
    end

    // Control delay line lines bf_* up with read data returning RD_LAT cycles later.
    always_comb begin
        pipe_d    = pipe_q;
        pipe_d[0] = {rd_en, cur_ictrl, (rd_en ? k_q : KW'(0))};
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
        {bf_iact, bf_ictrl, bf_addr} = pipe_q[RD_LAT-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            stage_q <= '0;
            k_q     <= '0;
            outst_q <= '0;
            pipe_q  <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            k_q     <= k_d;
            outst_q <= outst_d;
            pipe_q  <= pipe_d;
        end
    end

endmodule
